alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
// - Issue stage directly upstream of the signed 16-bit ALU: holds the 16x16 register file and reads rs/rt (or an immediate).
// - Registers {a, b, function, rd} into the ALU input pipeline register.
// - Tracks in-flight destinations with a scoreboard and stalls on RAW/WAW hazards.
// - Accepts ALU writeback, including the divide remainder written to R15.
// PARAMETERS
// - DATA_W      16  operand/register width (signed two's complement)
// - REG_ADDR_W   4  register index width (16 registers, R0..R15)
// - FUNC_W       4  ALU function code width
// - REM_REG     15  register index that receives the division remainder
// - DIV_FUNC   4'b0101  function code whose issue also reserves REM_REG
// PORTS
// - clk          in   1         rising-edge clock
// - rst          in   1         synchronous, active-high reset
// - in_valid     in   1         decoded instruction present
// - in_ready     out  1         stage accepts instruction this cycle
// - in_func      in   FUNC_W    ALU function code
// - in_rs        in   REG_ADDR_W  source A register
// - in_rt        in   REG_ADDR_W  source B register (ignored when in_imm_en)
// - in_rd        in   REG_ADDR_W  destination register
// - in_imm_en    in   1         select in_imm as operand B
// - in_imm       in   DATA_W    immediate operand B
// - wb_en        in   1         write wb_data to wb_addr
// - wb_addr      in   REG_ADDR_W  writeback destination
// - wb_data      in   DATA_W    writeback value (ALU out)
// - wb_rem_en    in   1         write wb_rem to REM_REG
// - wb_rem       in   DATA_W    division remainder
// - out_valid    out  1         ALU input register holds an instruction
// - out_ready    in   1         ALU/next stage consumes out_* this cycle
// - out_a        out  DATA_W    ALU operand a
// - out_b        out  DATA_W    ALU operand b
// - out_func     out  FUNC_W    ALU function
// - out_rd       out  REG_ADDR_W  destination carried to writeback
// BEHAVIOUR
// - Reset (sync, rst=1 at posedge): all 16 registers=0, scoreboard=0, out_valid=0, out_a=out_b=0, out_func=0, out_rd=0.
//   Reset mid-operation discards the held instruction and all pending reservations.
// - Regfile write at posedge: wb_en -> R[wb_addr]=wb_data; wb_rem_en -> R[REM_REG]=wb_rem.
//   If both target REM_REG in the same cycle, wb_rem wins.
// - Read bypass: a read of a register being written in the same cycle returns the new value, using the same priority (wb_rem over wb_data).
// - Scoreboard: 16 pending bits.
//   - Bit clear: wb_en clears bit[wb_addr]; wb_rem_en clears bit[REM_REG].
//   - Bit set on accept (in_valid && in_ready): bit[in_rd]; also bit[REM_REG] when in_func==DIV_FUNC.
//   - Set and clear of the same bit in the same cycle -> set wins.
// - Hazard: haz = pend_eff[in_rs] | (!in_imm_en & pend_eff[in_rt]) | pend_eff[in_rd] | (in_func==DIV_FUNC & pend_eff[REM_REG]).
//   pend_eff = scoreboard with this cycle's writeback clears already applied.
// - in_ready = !haz && (!out_valid || out_ready). Combinational; no dependence on in_valid.
// - Output register loads on accept: out_a=R'[in_rs], out_b=in_imm_en?in_imm:R'[in_rt], out_func=in_func, out_rd=in_rd, out_valid=1 (R' = bypassed read).
//   Latency: 1 cycle from accept to out_valid.
// - Otherwise, if out_ready: out_valid=0, data regs hold last value.
// - Stall (out_valid && !out_ready): all out_* held stable.
// - Function codes are not checked; unknown codes pass through unchanged and reserve only in_rd.
// - Full throughput: back-to-back independent instructions accepted every cycle when out_ready=1.
// TESTING
// 1. Reset, then wb R3=0x7FFF, R4=0x0001; issue func=0000 rs=3 rt=4 rd=5 -> next cycle out_valid=1, out_a=0x7FFF, out_b=0x0001, out_func=0000, out_rd=5.
// 2. RAW: issue rd=5, then rs=5 -> in_ready=0 until wb_en addr=5 data=0x1234; in that same cycle in_ready=1 and out_a=0x1234 next cycle.
// 3. Divide: func=0101 rd=2 reserves R2 and R15; an instruction reading R15 stalls until wb_rem_en (wb_rem=0xFFFF) -> out_a=0xFFFF.
// 4. Conflict: wb_en addr=15 data=0x0011 with wb_rem_en data=0x0022 same cycle -> R15 reads 0x0022.
// 5. Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* unchanged; out_ready=1 -> next instruction loads.
// 6. rst asserted while out_valid=1 and R7 pending -> next cycle out_valid=0, scoreboard clear, R7 reads 0.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Issue stage in front of the 16-bit ALU: register file with writeback bypass,
// destination scoreboard for RAW/WAW stalls, and the ALU input pipeline register.
module alu_operand_stage #(
  parameter int                DATA_W     = 16,
  parameter int                REG_ADDR_W = 4,
  parameter int                FUNC_W     = 4,
  parameter int                REM_REG    = 15,
  parameter logic [FUNC_W-1:0] DIV_FUNC   = 4'b0101
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FUNC_W-1:0]     in_func,
  input  logic [REG_ADDR_W-1:0] in_rs,
  input  logic [REG_ADDR_W-1:0] in_rt,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_imm_en,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  wb_rem_en,
  input  logic [DATA_W-1:0]     wb_rem,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_a,
  output logic [DATA_W-1:0]     out_b,
  output logic [FUNC_W-1:0]     out_func,
  output logic [REG_ADDR_W-1:0] out_rd
);

  localparam int                    NREG     = 1 << REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] REM_ADDR = REG_ADDR_W'(REM_REG);

  typedef struct packed {
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic [FUNC_W-1:0]     func;
    logic [REG_ADDR_W-1:0] rd;
  } issue_t;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pend, pend_eff, clr_mask, set_mask;
  logic              is_div, haz, accept;
  logic [DATA_W-1:0] rd_a, rd_b;
  issue_t            issue_d, issue_q;
  logic              vld_q;

  assign is_div = (in_func == DIV_FUNC);

  // Bypass: same-cycle writeback is visible to the read; remainder beats ALU data on R15.
  assign rd_a = (wb_rem_en && in_rs == REM_ADDR) ? wb_rem :
                (wb_en && in_rs == wb_addr)      ? wb_data : regs[in_rs];
  assign rd_b = (wb_rem_en && in_rt == REM_ADDR) ? wb_rem :
                (wb_en && in_rt == wb_addr)      ? wb_data : regs[in_rt];

  always_comb begin
    clr_mask = '0;
    if (wb_en)     clr_mask[wb_addr]  = 1'b1;
    if (wb_rem_en) clr_mask[REM_ADDR] = 1'b1;
  end

  assign pend_eff = pend & ~clr_mask;

  assign haz = pend_eff[in_rs]
             | (!in_imm_en & pend_eff[in_rt])
             | pend_eff[in_rd]
             | (is_div & pend_eff[REM_ADDR]);

  assign in_ready = !haz && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    set_mask = '0;
    if (accept) begin
      set_mask[in_rd] = 1'b1;
      if (is_div) set_mask[REM_ADDR] = 1'b1;
    end
  end

  always_comb begin
    issue_d.a    = rd_a;
    issue_d.b    = in_imm_en ? in_imm : rd_b;
    issue_d.func = in_func;
    issue_d.rd   = in_rd;
  end

  // Remainder write is last so it wins a same-cycle collision on R15.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wb_en)     regs[wb_addr]  <= wb_data;
      if (wb_rem_en) regs[REM_ADDR] <= wb_rem;
    end
  end

  // Set after clear: a new reservation survives a retiring writeback to the same reg.
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_eff | set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      issue_q <= '0;
    end else if (accept) begin
      vld_q   <= 1'b1;
      issue_q <= issue_d;
    end else if (out_ready) begin
      vld_q   <= 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign out_a     = issue_q.a;
  assign out_b     = issue_q.b;
  assign out_func  = issue_q.func;
  assign out_rd    = issue_q.rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios plus random traffic, all
// cycles checked against an array-based model of regfile, pending set and output reg.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_imm_en;
  logic [3:0]  in_func, in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic        wb_en, wb_rem_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data, wb_rem;
  logic        out_valid, out_ready;
  logic [15:0] out_a, out_b;
  logic [3:0]  out_func, out_rd;

  alu_operand_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm_en(in_imm_en), .in_imm(in_imm),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_rem_en(wb_rem_en), .wb_rem(wb_rem),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_func(out_func), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference state
  logic [15:0] m_regs [16];
  bit          m_pend [16];
  bit          m_ov;
  logic [15:0] m_a, m_b;
  logic [3:0]  m_f, m_rd;

  function automatic logic [15:0] rdval(input logic [3:0] r);
    if (wb_rem_en && r == 4'd15) return wb_rem;
    if (wb_en && r == wb_addr)   return wb_data;
    return m_regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 16'h0;
      m_pend[i] = 1'b0;
    end
    m_ov = 1'b0; m_a = 16'h0; m_b = 16'h0; m_f = 4'h0; m_rd = 4'h0;
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic cyc(input string tag);
    bit          pe [16];
    bit          haz, rdy, acc;
    logic [15:0] va, vb;
    #1;
    for (int i = 0; i < 16; i++)
      pe[i] = m_pend[i] && !(wb_en && wb_addr == 4'(i)) && !(wb_rem_en && i == 15);
    haz = pe[in_rs] || (!in_imm_en && pe[in_rt]) || pe[in_rd] || (in_func == 4'd5 && pe[15]);
    rdy = !haz && (!m_ov || out_ready);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    acc = in_valid && rdy;
    va  = rdval(in_rs);
    vb  = in_imm_en ? in_imm : rdval(in_rt);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (wb_en)     m_regs[wb_addr] = wb_data;
      if (wb_rem_en) m_regs[15]      = wb_rem;
      for (int i = 0; i < 16; i++) m_pend[i] = pe[i];
      if (acc) begin
        m_pend[in_rd] = 1'b1;
        if (in_func == 4'd5) m_pend[15] = 1'b1;
        m_ov = 1'b1; m_a = va; m_b = vb; m_f = in_func; m_rd = in_rd;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".out_a"},     32'(out_a),     32'(m_a));
    chk({tag, ".out_b"},     32'(out_b),     32'(m_b));
    chk({tag, ".out_func"},  32'(out_func),  32'(m_f));
    chk({tag, ".out_rd"},    32'(out_rd),    32'(m_rd));
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; in_valid = 1'b0; in_imm_en = 1'b0; wb_en = 1'b0; wb_rem_en = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic issue(input logic [3:0] f, input logic [3:0] rs, input logic [3:0] rt,
                       input logic [3:0] rd);
    in_valid = 1'b1; in_func = f; in_rs = rs; in_rt = rt; in_rd = rd; in_imm_en = 1'b0;
  endtask

  task automatic wb(input logic [3:0] a, input logic [15:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    in_func = 4'h0; in_rs = 4'h0; in_rt = 4'h0; in_rd = 4'h0; in_imm = 16'h0;
    wb_addr = 4'h0; wb_data = 16'h0; wb_rem = 16'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("reset.out_valid", 32'(out_valid), 32'h0);
    chk("reset.out_a",     32'(out_a),     32'h0);
    chk("reset.out_b",     32'(out_b),     32'h0);
    chk("reset.out_func",  32'(out_func),  32'h0);
    chk("reset.out_rd",    32'(out_rd),    32'h0);
    chk("reset.in_ready",  32'(in_ready),  32'h1);
    @(negedge clk);

    // 1: basic issue
    idle(); wb(4'd3, 16'h7FFF); cyc("t1w3");
    idle(); wb(4'd4, 16'h0001); cyc("t1w4");
    idle(); issue(4'h0, 4'd3, 4'd4, 4'd5); cyc("t1i");
    chk("t1.out_valid", 32'(out_valid), 32'h1);
    chk("t1.out_a",     32'(out_a),     32'h7FFF);
    chk("t1.out_b",     32'(out_b),     32'h0001);
    chk("t1.out_rd",    32'(out_rd),    32'h5);
    idle(); wb(4'd5, 16'h8000); cyc("t1c");

    // 2: RAW stall resolved by writeback with bypass
    idle(); issue(4'h0, 4'd0, 4'd0, 4'd5); cyc("t2i");
    idle(); issue(4'h1, 4'd5, 4'd0, 4'd6); cyc("t2s0");
    chk("t2.stall", 32'(in_ready), 32'h0);
    cyc("t2s1");
    wb(4'd5, 16'h1234); cyc("t2r");
    chk("t2.out_a", 32'(out_a), 32'h1234);
    idle(); wb(4'd6, 16'h0); cyc("t2c");

    // 3: divide reserves R15 too
    idle(); issue(4'b0101, 4'd0, 4'd0, 4'd2); cyc("t3i");
    idle(); issue(4'h0, 4'd15, 4'd0, 4'd7); cyc("t3s");
    chk("t3.stall", 32'(in_ready), 32'h0);
    wb_rem_en = 1'b1; wb_rem = 16'hFFFF; cyc("t3r");
    chk("t3.out_a", 32'(out_a), 32'hFFFF);
    idle(); wb(4'd2, 16'h0002); cyc("t3c2");
    idle(); wb(4'd7, 16'h0007); cyc("t3c7");

    // 4: same-cycle collision on R15, remainder wins (bypass and stored)
    idle(); wb(4'd15, 16'h0011); wb_rem_en = 1'b1; wb_rem = 16'h0022;
    issue(4'h0, 4'd15, 4'd15, 4'd8); cyc("t4b");
    chk("t4.bypass", 32'(out_a), 32'h0022);
    idle(); issue(4'h0, 4'd15, 4'd0, 4'd9); cyc("t4r");
    chk("t4.stored", 32'(out_a), 32'h0022);
    idle(); wb(4'd8, 16'h0); cyc("t4c8");
    idle(); wb(4'd9, 16'h0); cyc("t4c9");

    // 5: backpressure
    idle(); issue(4'h2, 4'd1, 4'd1, 4'd10); cyc("t5i");
    idle(); issue(4'h3, 4'd1, 4'd1, 4'd11); out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc("t5s");
      chk("t5.stall", 32'(in_ready), 32'h0);
      chk("t5.hold",  32'(out_rd),   32'hA);
    end
    out_ready = 1'b1; cyc("t5go");
    chk("t5.next", 32'(out_rd), 32'hB);

    // 6: reset mid-flight
    idle(); issue(4'h0, 4'd0, 4'd0, 4'd7); cyc("t6i");
    idle(); rst = 1'b1; cyc("t6r");
    chk("t6.out_valid", 32'(out_valid), 32'h0);
    idle(); issue(4'h0, 4'd7, 4'd7, 4'd7); cyc("t6a");
    chk("t6.accept", 32'(out_valid), 32'h1);
    chk("t6.r7",     32'(out_a),     32'h0);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_func   = ($urandom_range(0, 3) == 0) ? 4'd5 : 4'($urandom_range(0, 15));
      in_rs     = 4'($urandom_range(0, 15));
      in_rt     = 4'($urandom_range(0, 15));
      in_rd     = 4'($urandom_range(0, 15));
      in_imm_en = 1'($urandom_range(0, 1));
      in_imm    = 16'($urandom);
      wb_en     = ($urandom_range(0, 2) != 0);
      wb_addr   = 4'($urandom_range(0, 15));
      wb_data   = 16'($urandom);
      wb_rem_en = ($urandom_range(0, 4) == 0);
      wb_rem    = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
